// File: rtl/bit_stuff_engine.sv
// Serial bit-stuffing engine: TX inserts a 0 after RUN_LEN consecutive 1s, RX removes and checks it.
// Optional macro BIT_STUFF_STATS_EN adds a 16-bit stuff-event counter output (stuff_cnt).
module bit_stuff_engine #(
  parameter int unsigned RUN_LEN  = 6,
  parameter int unsigned CNT_BITS = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                mode,
  input  logic                d_in,
  input  logic                sync_clr,
  input  logic                err_clr,
  output logic                d_out,
  output logic                d_valid,
  output logic                tx_hold,
  output logic                stuff_bit,
  output logic                stuff_err,
  output logic [CNT_BITS-1:0] run_count
`ifdef BIT_STUFF_STATS_EN
  ,
  output logic [15:0]         stuff_cnt
`endif
);

  localparam logic [CNT_BITS-1:0] RUN_MAX = CNT_BITS'(RUN_LEN);

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    STUFF = 2'd1,
    SKIP  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt_nxt;
  logic                mode_q;
  logic                clr;
  logic                err_set;
  logic                stuff_entry;

  // A mode switch mid-packet is treated exactly like a packet-boundary clear.
  always_comb clr = sync_clr | (mode ^ mode_q);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = run_count;
    err_set     = 1'b0;
    stuff_entry = 1'b0;
    d_out       = d_in;
    d_valid     = 1'b0;
    tx_hold     = 1'b0;
    stuff_bit   = 1'b0;

    case (state)
      COUNT: begin
        d_valid = shift_enable;
        if (shift_enable) begin
          if (d_in) begin
            cnt_nxt = run_count + 1'b1;
            if (cnt_nxt == RUN_MAX) begin
              state_nxt   = mode ? SKIP : STUFF;
              stuff_entry = 1'b1;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      STUFF: begin
        d_out     = 1'b0;
        d_valid   = shift_enable;
        tx_hold   = 1'b1;
        stuff_bit = 1'b1;
        if (shift_enable) begin
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
      end
      SKIP: begin
        stuff_bit = 1'b1;
        if (shift_enable) begin
          cnt_nxt = '0;
          if (d_in) begin
            state_nxt = ERR;
            err_set   = 1'b1;
          end else begin
            state_nxt = COUNT;
          end
        end
      end
      ERR: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = COUNT;
        cnt_nxt   = '0;
      end
    endcase

    if (clr) begin
      state_nxt   = COUNT;
      cnt_nxt     = '0;
      err_set     = 1'b0;
      stuff_entry = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= COUNT;
      run_count <= '0;
      mode_q    <= mode;
      stuff_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_count <= cnt_nxt;
      mode_q    <= mode;
      if (err_set) begin
        stuff_err <= 1'b1;
      end else if (err_clr) begin
        stuff_err <= 1'b0;
      end
    end
  end

`ifdef BIT_STUFF_STATS_EN
  always_ff @(posedge clk) begin
    if (!n_rst || clr) begin
      stuff_cnt <= '0;
    end else if (stuff_entry) begin
      stuff_cnt <= stuff_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit_stuff_engine.sv
// Self-checking bench for bit_stuff_engine: vector table through a scoreboard queue,
// plus a RUN_LEN=2 instance exercised by a hand-written sequence.
module tb_bit_stuff_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, shift_enable, mode, d_in, sync_clr, err_clr;
  logic       d_out, d_valid, tx_hold, stuff_bit, stuff_err;
  logic [2:0] run_count;

  logic       b_shift_enable, b_mode, b_d_in, b_sync_clr, b_err_clr;
  logic       b_d_out, b_d_valid, b_tx_hold, b_stuff_bit, b_stuff_err;
  logic [1:0] b_run_count;

`ifdef BIT_STUFF_STATS_EN
  logic [15:0] stuff_cnt, b_stuff_cnt;
`endif

  bit_stuff_engine #(.RUN_LEN(6), .CNT_BITS(3)) u_dut (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .mode(mode),
    .d_in(d_in), .sync_clr(sync_clr), .err_clr(err_clr),
    .d_out(d_out), .d_valid(d_valid), .tx_hold(tx_hold),
    .stuff_bit(stuff_bit), .stuff_err(stuff_err), .run_count(run_count)
`ifdef BIT_STUFF_STATS_EN
    , .stuff_cnt(stuff_cnt)
`endif
  );

  bit_stuff_engine #(.RUN_LEN(2), .CNT_BITS(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .shift_enable(b_shift_enable), .mode(b_mode),
    .d_in(b_d_in), .sync_clr(b_sync_clr), .err_clr(b_err_clr),
    .d_out(b_d_out), .d_valid(b_d_valid), .tx_hold(b_tx_hold),
    .stuff_bit(b_stuff_bit), .stuff_err(b_stuff_err), .run_count(b_run_count)
`ifdef BIT_STUFF_STATS_EN
    , .stuff_cnt(b_stuff_cnt)
`endif
  );

  typedef struct {
    logic       n_rst, sync_clr, err_clr, mode, shift_enable, d_in;
    logic       d_out, d_valid, tx_hold, stuff_bit, stuff_err;
    logic [2:0] run_count;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, sc, ec, md, se, di, dout, dv, th, sb, er, input logic [2:0] cnt);
    vec_t v;
    v.n_rst = r; v.sync_clr = sc; v.err_clr = ec; v.mode = md; v.shift_enable = se; v.d_in = di;
    v.d_out = dout; v.d_valid = dv; v.tx_hold = th; v.stuff_bit = sb; v.stuff_err = er;
    v.run_count = cnt;
    vecs.push_back(v);
  endtask

  // n shifted 1s from a COUNT state starting at run count c0
  task automatic add_ones(input int n, input logic md, input int c0);
    for (int k = 0; k < n; k++) add(1, 0, 0, md, 1, 1, 1, 1, 0, 0, 0, 3'(c0 + k));
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    n_rst = v.n_rst; sync_clr = v.sync_clr; err_clr = v.err_clr;
    mode = v.mode; shift_enable = v.shift_enable; d_in = v.d_in;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check("d_out",     idx, 16'(d_out),     16'(e.d_out));
    check("d_valid",   idx, 16'(d_valid),   16'(e.d_valid));
    check("tx_hold",   idx, 16'(tx_hold),   16'(e.tx_hold));
    check("stuff_bit", idx, 16'(stuff_bit), 16'(e.stuff_bit));
    check("stuff_err", idx, 16'(stuff_err), 16'(e.stuff_err));
    check("run_count", idx, 16'(run_count), 16'(e.run_count));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b_bits, b_exp_out, b_exp_hold, b_exp_valid;
    logic [1:0] b_exp_cnt [4];

    n_rst = 0; shift_enable = 0; mode = 0; d_in = 0; sync_clr = 0; err_clr = 0;
    b_shift_enable = 0; b_mode = 0; b_d_in = 0; b_sync_clr = 0; b_err_clr = 0;
    repeat (2) @(posedge clk);

    // after reset
    add(1,0,0,0,0,1, 1,0,0,0,0,0);
    // TX: 1111111 0 with a held cycle inside STUFF
    add_ones(6, 0, 0);
    add(1,0,0,0,0,1, 0,0,1,1,0,6);
    add(1,0,0,0,1,1, 0,1,1,1,0,6);
    add(1,0,0,0,1,1, 1,1,0,0,0,0);
    add(1,0,0,0,1,0, 0,1,0,0,0,1);
    // RX: 111111 0 1
    add(1,0,0,1,0,0, 0,0,0,0,0,0);
    add_ones(6, 1, 0);
    add(1,0,0,1,1,0, 0,0,0,1,0,6);
    add(1,0,0,1,1,1, 1,1,0,0,0,0);
    add(1,0,0,1,1,0, 0,1,0,0,0,1);
    // RX violation, err_clr colliding with the set, sync_clr exit, later err_clr
    add_ones(6, 1, 0);
    add(1,0,1,1,1,1, 1,0,0,1,0,6);
    add(1,0,0,1,1,1, 1,0,0,0,1,0);
    add(1,1,0,1,1,0, 0,0,0,0,1,0);
    add(1,0,1,1,1,1, 1,1,0,0,1,0);
    add(1,0,0,1,1,0, 0,1,0,0,0,1);
    // TX: 11111 0 11111, no stuff
    add(1,0,0,0,0,0, 0,0,0,0,0,0);
    add_ones(5, 0, 0);
    add(1,0,0,0,1,0, 0,1,0,0,0,5);
    add_ones(5, 0, 0);
    add(1,0,0,0,0,0, 0,0,0,0,0,5);
    // sync_clr beats shift_enable at run_count 5
    add(1,1,0,0,1,1, 1,1,0,0,0,5);
    add(1,0,0,0,0,0, 0,0,0,0,0,0);
    // reset while in STUFF
    add_ones(6, 0, 0);
    add(0,0,0,0,1,1, 0,1,1,1,0,6);
    add(1,0,0,0,0,1, 1,0,0,0,0,0);
    // mode change mid-run clears the count
    add_ones(3, 0, 0);
    add(1,0,0,1,1,1, 1,1,0,0,0,3);
    add(1,0,0,1,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // RUN_LEN=2 instance, TX 111 -> 11 0 1
    b_bits      = 4'b1111;
    b_exp_out   = 4'b1011;   // index 0 is the first bit time
    b_exp_hold  = 4'b0100;
    b_exp_valid = 4'b1111;
    b_exp_cnt   = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_shift_enable = 1; b_d_in = b_bits[i];
      #2;
      check("b_d_out",     i, 16'(b_d_out),     16'(b_exp_out[i]));
      check("b_tx_hold",   i, 16'(b_tx_hold),   16'(b_exp_hold[i]));
      check("b_stuff_bit", i, 16'(b_stuff_bit), 16'(b_exp_hold[i]));
      check("b_d_valid",   i, 16'(b_d_valid),   16'(b_exp_valid[i]));
      check("b_run_count", i, 16'(b_run_count), 16'(b_exp_cnt[i]));
      check("b_stuff_err", i, 16'(b_stuff_err), 16'd0);
    end
    @(negedge clk);
    b_shift_enable = 0;

`ifdef BIT_STUFF_STATS_EN
    @(negedge clk);
    mode = 0; sync_clr = 1; shift_enable = 0; n_rst = 1; err_clr = 0;
    @(negedge clk);
    sync_clr = 0;
    #2;
    check("stuff_cnt_clr", 0, stuff_cnt, 16'd0);
    for (int ev = 0; ev < 3; ev++) begin
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        shift_enable = 1; d_in = 1;
      end
      @(negedge clk);
      d_in = 0;
    end
    @(negedge clk);
    shift_enable = 0;
    #2;
    check("stuff_cnt", 3, stuff_cnt, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_stuff_engine.md
BIT_STUFF_ENGINE -- requirements
Module: bit_stuff_engine

Interface
REQ-001 Parameter RUN_LEN, default 6, number of consecutive 1 bits that triggers a stuff event; legal range 2..15.
REQ-002 Parameter CNT_BITS, default 3, run counter width; SHALL satisfy 2**CNT_BITS > RUN_LEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 shift_enable  input  1  one-cycle strobe marking a bit time; all bit processing is gated by it.
REQ-006 mode  input  1  0 = TX (insert stuff bits), 1 = RX (remove and check stuff bits).
REQ-007 d_in  input  1  serial data bit for the current bit time.
REQ-008 sync_clr  input  1  synchronous clear of run counter and FSM (packet boundary/EOP).
REQ-009 err_clr  input  1  clears sticky stuff_err.
REQ-010 d_out  output  1  serial data out, combinational from state and d_in.
REQ-011 d_valid  output  1  high when d_out carries a payload bit this bit time.
REQ-012 tx_hold  output  1  TX only: upstream SHALL NOT advance its bit on this bit time.
REQ-013 stuff_bit  output  1  high while FSM is in STUFF or SKIP.
REQ-014 stuff_err  output  1  sticky RX stuff violation flag.
REQ-015 run_count  output  CNT_BITS  current count of consecutive 1s.

Function
REQ-016 FSM states: COUNT, STUFF (TX), SKIP (RX), ERR (RX); encoded in registers, next-state logic separate.
REQ-017 With shift_enable=0, all registers SHALL hold; d_valid=0; tx_hold, stuff_bit, d_out reflect current state.
REQ-018 COUNT, shift_enable=1: d_in=1 -> run_count+1; d_in=0 -> run_count=0; d_out=d_in; d_valid=1.
REQ-019 COUNT: when a shifted 1 makes run_count equal RUN_LEN, next state SHALL be STUFF if mode=0, SKIP if mode=1; run_count never exceeds RUN_LEN.
REQ-020 STUFF: d_out=0, d_valid=1, tx_hold=1, d_in ignored; on shift_enable -> run_count=0, state COUNT.
REQ-021 SKIP: d_out=d_in, d_valid=0; on shift_enable with d_in=0 -> run_count=0, COUNT; with d_in=1 -> ERR, stuff_err=1 next cycle.
REQ-022 ERR: d_valid=0, run_count=0 held; exit to COUNT only via sync_clr or reset; stuff_err stays set.
REQ-023 stuff_err SHALL be sticky: cleared by err_clr or reset; simultaneous set and err_clr -> set wins.
REQ-024 sync_clr SHALL have priority over shift_enable: run_count=0, state COUNT next cycle; stuff_err unaffected.
REQ-025 A mode change (mode differs from registered mode_q) SHALL act as sync_clr on that cycle; mode_q updates every cycle.
REQ-026 Latency: stuff bit occupies the bit time immediately after the RUN_LEN-th 1; no extra idle bit times inserted.
REQ-027 A 0 in the RUN_LEN-th position (run_count=RUN_LEN-1, d_in=0) SHALL reset count with no stuff event.

Reset
REQ-028 On n_rst=0 at a rising edge: state=COUNT, run_count=0, mode_q=mode, stuff_err=0, stats counter=0.
REQ-029 Outputs after reset: d_out=d_in, d_valid=0 until shift_enable, tx_hold=0, stuff_bit=0, stuff_err=0, run_count=0.
REQ-030 Reset mid-STUFF/SKIP/ERR SHALL abandon the event with no stuff bit emitted.

Configuration
REQ-031 Macro BIT_STUFF_STATS_EN: when defined, adds output stuff_cnt (16 bits) counting stuff events (entries to STUFF or SKIP), wrapping 0xFFFF->0, cleared by reset or sync_clr.
REQ-032 Without BIT_STUFF_STATS_EN, port stuff_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 TX, RUN_LEN=6, bits 1111111 0 -> d_out 111111 0 1 0, tx_hold high exactly one bit time after 6th 1, stuff_bit matches.
REQ-034 RX, bits 111111 0 1 -> 7th bit d_valid=0, payload 111111 then 1, stuff_err=0.
REQ-035 RX, bits 1111111 -> 7th bit enters ERR, stuff_err=1 next cycle, d_valid=0 until sync_clr; err_clr same cycle as set -> stays 1.
REQ-036 Bits 11111 0 11111 -> no stuff event, run_count returns to 0 after the 0, reaches 5 at end.
REQ-037 sync_clr asserted with shift_enable at run_count=5 -> run_count=0, no stuff; n_rst=0 while in STUFF -> COUNT, tx_hold=0.
REQ-038 With BIT_STUFF_STATS_EN, 3 stuff events -> stuff_cnt=3; RUN_LEN=2 build, TX 111 -> d_out 11 0 1.
